// File: rtl/csc_iact_sram_writer.sv
// Writes the CSC address and data streams into a ping-pong iact SRAM pair and
// hands each completed bank to the PE-side reader via bank_valid / bank_release.
module csc_iact_sram_writer #(
    parameter int ADDR_WIDTH  = 7,
    parameter int COUNT_WIDTH = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 6
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              address_in_valid,
    output logic                              address_in_ready,
    input  logic [ADDR_WIDTH-1:0]             address_in,
    input  logic                              data_in_valid,
    output logic                              data_in_ready,
    input  logic [DATA_WIDTH+COUNT_WIDTH-1:0] data_in,
    output logic                              data_sram_we,
    output logic [DEPTH_WIDTH:0]              data_sram_addr,
    output logic [DATA_WIDTH+COUNT_WIDTH-1:0] data_sram_wdata,
    output logic                              addr_sram_we,
    output logic [DEPTH_WIDTH:0]              addr_sram_addr,
    output logic [ADDR_WIDTH-1:0]             addr_sram_wdata,
    output logic [1:0]                        bank_valid,
    input  logic [1:0]                        bank_release,
    output logic                              vector_done,
    output logic                              vector_bank,
    output logic [DEPTH_WIDTH:0]              vector_data_len,
    output logic [DEPTH_WIDTH:0]              vector_addr_len,
    output logic                              overflow
);

    localparam logic [DEPTH_WIDTH-1:0] LAST_INDEX = '1;

    typedef enum logic [1:0] {IDLE, STALL, FILL, COMMIT} state_t;

    state_t                 state, state_next;
    logic                   wr_bank;
    logic [DEPTH_WIDTH-1:0] data_ptr, addr_ptr;
    logic [DEPTH_WIDTH:0]   data_count, addr_count;
    logic                   data_term_seen, addr_term_seen;

    logic addr_fire, addr_is_term, addr_drop, addr_keep;
    logic data_fire, data_is_term, data_drop, data_keep;
    logic [1:0] commit_mask;

    assign address_in_ready = (state == FILL) && !addr_term_seen;
    assign data_in_ready    = (state == FILL) && !data_term_seen;

    assign addr_fire    = address_in_valid && address_in_ready;
    assign addr_is_term = (address_in == '0);
    // A full bank still accepts words so the stream drains; only the terminator may land on the last index.
    assign addr_drop    = addr_fire && !addr_is_term && (addr_ptr == LAST_INDEX);
    assign addr_keep    = addr_fire && !addr_drop;

    assign data_fire    = data_in_valid && data_in_ready;
    assign data_is_term = (data_in == '0);
    assign data_drop    = data_fire && !data_is_term && (data_ptr == LAST_INDEX);
    assign data_keep    = data_fire && !data_drop;

    assign commit_mask  = (state == COMMIT) ? (2'b01 << wr_bank) : 2'b00;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = bank_valid[wr_bank] ? STALL : FILL;
            STALL:   if (!bank_valid[wr_bank]) state_next = FILL;
            FILL: begin
                if ((addr_term_seen || (addr_fire && addr_is_term)) &&
                    (data_term_seen || (data_fire && data_is_term)))
                    state_next = COMMIT;
            end
            COMMIT:  state_next = bank_valid[~wr_bank] ? STALL : FILL;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            wr_bank         <= 1'b0;
            data_ptr        <= '0;
            addr_ptr        <= '0;
            data_count      <= '0;
            addr_count      <= '0;
            data_term_seen  <= 1'b0;
            addr_term_seen  <= 1'b0;
            data_sram_we    <= 1'b0;
            data_sram_addr  <= '0;
            data_sram_wdata <= '0;
            addr_sram_we    <= 1'b0;
            addr_sram_addr  <= '0;
            addr_sram_wdata <= '0;
            bank_valid      <= 2'b00;
            vector_done     <= 1'b0;
            vector_bank     <= 1'b0;
            vector_data_len <= '0;
            vector_addr_len <= '0;
            overflow        <= 1'b0;
        end else begin
            state        <= state_next;
            data_sram_we <= data_keep;
            addr_sram_we <= addr_keep;
            vector_done  <= 1'b0;
            // Commit wins over a same-cycle release of the bank being committed.
            bank_valid   <= (bank_valid & ~bank_release) | commit_mask;

            if (data_keep) begin
                data_sram_addr  <= {wr_bank, data_ptr};
                data_sram_wdata <= data_in;
                data_count      <= data_count + 1'b1;
                if (!data_is_term) data_ptr <= data_ptr + 1'b1;
            end
            if (addr_keep) begin
                addr_sram_addr  <= {wr_bank, addr_ptr};
                addr_sram_wdata <= address_in;
                addr_count      <= addr_count + 1'b1;
                if (!addr_is_term) addr_ptr <= addr_ptr + 1'b1;
            end
            if (data_fire && data_is_term) data_term_seen <= 1'b1;
            if (addr_fire && addr_is_term) addr_term_seen <= 1'b1;
            if (data_drop || addr_drop)    overflow       <= 1'b1;

            if (state == COMMIT) begin
                vector_done     <= 1'b1;
                vector_bank     <= wr_bank;
                vector_data_len <= data_count;
                vector_addr_len <= addr_count;
                wr_bank         <= ~wr_bank;
                data_ptr        <= '0;
                addr_ptr        <= '0;
                data_count      <= '0;
                addr_count      <= '0;
                data_term_seen  <= 1'b0;
                addr_term_seen  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csc_iact_sram_writer.sv
// Scoreboard bench for csc_iact_sram_writer: a vector-level model predicts every
// SRAM write and commit; a negedge monitor compares them as the DUT produces them.
module tb_csc_iact_sram_writer;

    localparam int AW       = 7;
    localparam int CW       = 4;
    localparam int VW       = 8;
    localparam int DW       = 6;
    localparam int WW       = VW + CW;
    localparam int MAX_KEEP = (1 << DW) - 1;   // non-terminator words a bank can hold
    localparam int SDW      = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // main instance
    logic          address_in_valid, address_in_ready;
    logic [AW-1:0] address_in;
    logic          data_in_valid, data_in_ready;
    logic [WW-1:0] data_in;
    logic          data_sram_we, addr_sram_we;
    logic [DW:0]   data_sram_addr, addr_sram_addr;
    logic [WW-1:0] data_sram_wdata;
    logic [AW-1:0] addr_sram_wdata;
    logic [1:0]    bank_valid, bank_release;
    logic          vector_done, vector_bank, overflow;
    logic [DW:0]   vector_data_len, vector_addr_len;

    // small instance for the overflow case
    logic           s_address_in_valid, s_address_in_ready;
    logic [AW-1:0]  s_address_in;
    logic           s_data_in_valid, s_data_in_ready;
    logic [WW-1:0]  s_data_in;
    logic           s_data_sram_we, s_addr_sram_we;
    logic [SDW:0]   s_data_sram_addr, s_addr_sram_addr;
    logic [WW-1:0]  s_data_sram_wdata;
    logic [AW-1:0]  s_addr_sram_wdata;
    logic [1:0]     s_bank_valid, s_bank_release;
    logic           s_vector_done, s_vector_bank, s_overflow;
    logic [SDW:0]   s_vector_data_len, s_vector_addr_len;

    csc_iact_sram_writer #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .DATA_WIDTH(VW), .DEPTH_WIDTH(DW)) u_dut (
        .clock(clock), .reset(reset),
        .address_in_valid(address_in_valid), .address_in_ready(address_in_ready), .address_in(address_in),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready), .data_in(data_in),
        .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .addr_sram_we(addr_sram_we), .addr_sram_addr(addr_sram_addr), .addr_sram_wdata(addr_sram_wdata),
        .bank_valid(bank_valid), .bank_release(bank_release),
        .vector_done(vector_done), .vector_bank(vector_bank),
        .vector_data_len(vector_data_len), .vector_addr_len(vector_addr_len), .overflow(overflow)
    );

    csc_iact_sram_writer #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .DATA_WIDTH(VW), .DEPTH_WIDTH(SDW)) u_small (
        .clock(clock), .reset(reset),
        .address_in_valid(s_address_in_valid), .address_in_ready(s_address_in_ready), .address_in(s_address_in),
        .data_in_valid(s_data_in_valid), .data_in_ready(s_data_in_ready), .data_in(s_data_in),
        .data_sram_we(s_data_sram_we), .data_sram_addr(s_data_sram_addr), .data_sram_wdata(s_data_sram_wdata),
        .addr_sram_we(s_addr_sram_we), .addr_sram_addr(s_addr_sram_addr), .addr_sram_wdata(s_addr_sram_wdata),
        .bank_valid(s_bank_valid), .bank_release(s_bank_release),
        .vector_done(s_vector_done), .vector_bank(s_vector_bank),
        .vector_data_len(s_vector_data_len), .vector_addr_len(s_vector_addr_len), .overflow(s_overflow)
    );

    typedef struct packed {
        logic [DW:0]   addr;
        logic [WW-1:0] wdata;
    } wr_t;

    typedef struct packed {
        logic        bank;
        logic [DW:0] dlen;
        logic [DW:0] alen;
    } commit_t;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      last_wr_cyc = 0;
    int      first_we_cyc = 0;
    bit      track_first = 1'b0;
    wr_t     exp_data_q[$];
    wr_t     exp_addr_q[$];
    commit_t exp_commit_q[$];
    wr_t     w_pop;
    commit_t c_pop;

    logic [AW-1:0] vec_addr[$];
    logic [WW-1:0] vec_data[$];
    logic          mdl_bank = 1'b0;
    logic [1:0]    mdl_bv = 2'b00;

    logic [WW-1:0] s_mem [8];
    int            s_data_wr_count = 0;
    int            s_addr_wr_count = 0;
    logic [AW-1:0] s_last_addr_wdata = '1;
    bit            s_done_seen = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (data_sram_we) begin
            if (exp_data_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL data_write_unexpected: addr 0x%0h wdata 0x%0h, none expected", data_sram_addr, data_sram_wdata);
            end else begin
                w_pop = exp_data_q.pop_front();
                check("data_sram_addr", 32'(data_sram_addr), 32'(w_pop.addr));
                check("data_sram_wdata", 32'(data_sram_wdata), 32'(w_pop.wdata));
            end
            if (track_first) begin first_we_cyc = cyc; track_first = 1'b0; end
            last_wr_cyc = cyc;
        end
        if (addr_sram_we) begin
            if (exp_addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL addr_write_unexpected: addr 0x%0h wdata 0x%0h, none expected", addr_sram_addr, addr_sram_wdata);
            end else begin
                w_pop = exp_addr_q.pop_front();
                check("addr_sram_addr", 32'(addr_sram_addr), 32'(w_pop.addr));
                check("addr_sram_wdata", 32'(addr_sram_wdata), 32'(w_pop.wdata));
            end
            if (track_first) begin first_we_cyc = cyc; track_first = 1'b0; end
            last_wr_cyc = cyc;
        end
        if (vector_done) begin
            if (exp_commit_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL commit_unexpected: vector_done with bank %0d, none expected", vector_bank);
            end else begin
                c_pop = exp_commit_q.pop_front();
                check("vector_bank", 32'(vector_bank), 32'(c_pop.bank));
                check("vector_data_len", 32'(vector_data_len), 32'(c_pop.dlen));
                check("vector_addr_len", 32'(vector_addr_len), 32'(c_pop.alen));
                check("done_after_last_write", cyc, last_wr_cyc + 1);
            end
        end
    end

    always @(negedge clock) begin
        if (s_data_sram_we) begin
            s_mem[s_data_sram_addr] = s_data_sram_wdata;
            s_data_wr_count++;
        end
        if (s_addr_sram_we) begin
            s_addr_wr_count++;
            s_last_addr_wdata = s_addr_sram_wdata;
        end
        if (s_vector_done) s_done_seen = 1'b1;
    end

    // ---------------- reference model ----------------
    // Whole-vector prediction: the first MAX_KEEP non-terminators land at 0.., the rest
    // are dropped, the terminator lands right after the kept words.
    task automatic push_expect();
        int  nd, na, dk, ak, a;
        wr_t w;
        commit_t c;
        nd = vec_data.size() - 1;
        na = vec_addr.size() - 1;
        dk = (nd < MAX_KEEP) ? nd : MAX_KEEP;
        ak = (na < MAX_KEEP) ? na : MAX_KEEP;
        for (int i = 0; i <= dk; i++) begin
            a = (int'(mdl_bank) << DW) + i;
            w.addr  = a[DW:0];
            w.wdata = (i == dk) ? '0 : vec_data[i];
            exp_data_q.push_back(w);
        end
        for (int i = 0; i <= ak; i++) begin
            a = (int'(mdl_bank) << DW) + i;
            w.addr  = a[DW:0];
            w.wdata = (i == ak) ? '0 : WW'(vec_addr[i]);
            exp_addr_q.push_back(w);
        end
        c.bank = mdl_bank;
        a = dk + 1; c.dlen = a[DW:0];
        a = ak + 1; c.alen = a[DW:0];
        exp_commit_q.push_back(c);
        mdl_bv[mdl_bank] = 1'b1;
        mdl_bank = ~mdl_bank;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_vector(input int skew, input int gap_pct, input logic [1:0] rel_mask);
        int ai, di, na, nd, skew_cnt, budget;
        bit a_off, d_off;
        ai = 0; di = 0; skew_cnt = 0; budget = 3000;
        na = vec_addr.size();
        nd = vec_data.size();
        push_expect();
        while ((ai < na || di < nd) && budget > 0) begin
            @(negedge clock);
            budget--;
            a_off = (ai < na) && ($urandom_range(99) >= gap_pct);
            d_off = (di < nd) && ($urandom_range(99) >= gap_pct);
            if (skew > 0 && di == nd - 1) begin
                if (ai < na) d_off = 1'b0;
                else if (skew_cnt < skew) begin
                    check("skew_addr_ready_low", 32'(address_in_ready), 0);
                    check("skew_data_ready_high", 32'(data_in_ready), 1);
                    skew_cnt++;
                    d_off = 1'b0;
                end
            end
            address_in_valid = a_off;
            address_in       = a_off ? vec_addr[ai] : AW'($urandom);
            data_in_valid    = d_off;
            data_in          = d_off ? vec_data[di] : WW'($urandom);
            if (a_off && address_in_ready) ai++;
            if (d_off && data_in_ready) di++;
        end
        if (ai < na || di < nd) begin
            checks++; errors++;
            $display("FAIL drive_timeout: accepted addr %0d/%0d data %0d/%0d", ai, na, di, nd);
        end
        @(negedge clock);
        address_in_valid = 1'b0;
        data_in_valid    = 1'b0;
        bank_release     = rel_mask;
        @(negedge clock);
        bank_release     = 2'b00;
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((exp_data_q.size() + exp_addr_q.size() + exp_commit_q.size()) != 0 && b < 300) begin
            @(negedge clock);
            #1;
            b++;
        end
        if ((exp_data_q.size() + exp_addr_q.size() + exp_commit_q.size()) != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending data %0d addr %0d commit %0d",
                     exp_data_q.size(), exp_addr_q.size(), exp_commit_q.size());
            exp_data_q.delete(); exp_addr_q.delete(); exp_commit_q.delete();
        end
    endtask

    task automatic rel(input logic [1:0] mask);
        @(negedge clock);
        bank_release = mask;
        @(negedge clock);
        bank_release = 2'b00;
        mdl_bv = mdl_bv & ~mask;
        #1;
        check("bank_valid_after_release", 32'(bank_valid), 32'(mdl_bv));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_address_in_ready"}, 32'(address_in_ready), 0);
        check({tag, "_data_in_ready"}, 32'(data_in_ready), 0);
        check({tag, "_sram_we"}, 32'({data_sram_we, addr_sram_we}), 0);
        check({tag, "_sram_addr"}, 32'({data_sram_addr, addr_sram_addr}), 0);
        check({tag, "_sram_wdata"}, 32'({data_sram_wdata, addr_sram_wdata}), 0);
        check({tag, "_bank_valid"}, 32'(bank_valid), 0);
        check({tag, "_vector_outputs"}, 32'({vector_done, vector_bank, vector_data_len, vector_addr_len}), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    task automatic random_vector();
        int n;
        vec_addr.delete();
        vec_data.delete();
        n = $urandom_range(0, 10);
        for (int i = 0; i < n; i++)
            vec_addr.push_back(($urandom_range(4) == 0) ? 7'h7F : AW'($urandom_range(1, 126)));
        vec_addr.push_back('0);
        n = $urandom_range(0, 20);
        for (int i = 0; i < n; i++) vec_data.push_back(WW'($urandom_range(1, 4095)));
        vec_data.push_back('0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int di, b, rel_cyc;
        logic [WW-1:0] sw [6];

        address_in_valid = 1'b0; address_in = '0;
        data_in_valid = 1'b0; data_in = '0;
        bank_release = 2'b00;
        s_address_in_valid = 1'b0; s_address_in = '0;
        s_data_in_valid = 1'b0; s_data_in = '0;
        s_bank_release = 2'b00;
        foreach (s_mem[i]) s_mem[i] = '1;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;

        // single vector, no backpressure
        vec_addr = '{7'd3, 7'd5, 7'd0};
        vec_data = '{12'h071, 12'hFE0, 12'h042, 12'h033, 12'h050, 12'h000};
        drive_vector(0, 0, 2'b00);
        wait_drain();
        check("single_bank_valid", 32'(bank_valid), 2'b01);
        rel(2'b01);

        // reset in the middle of a fill (writer is on bank1 now)
        vec_data = '{12'h123, 12'h456, 12'h789};
        for (int i = 0; i < 3; i++) begin
            w_pop.addr  = (DW+1)'((1 << DW) + i);
            w_pop.wdata = vec_data[i];
            exp_data_q.push_back(w_pop);
        end
        di = 0; b = 0;
        while (di < 3 && b < 50) begin
            @(negedge clock);
            b++;
            data_in_valid = 1'b1;
            data_in = vec_data[di];
            if (data_in_ready) di++;
        end
        @(negedge clock);
        data_in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        mdl_bank = 1'b0;
        mdl_bv = 2'b00;
        wait_drain();

        // skewed termination into bank0, then a second vector into bank1
        vec_addr = '{7'd9, 7'h7F, 7'd0};
        vec_data = '{12'h011, 12'h022, 12'h033, 12'h000};
        drive_vector(10, 0, 2'b00);
        wait_drain();
        check("skew_bank_valid", 32'(bank_valid), 2'b01);
        random_vector();
        drive_vector(0, 0, 2'b00);
        wait_drain();
        check("pingpong_bank_valid", 32'(bank_valid), 2'b11);

        // stalled: offers must be refused
        address_in_valid = 1'b1; address_in = 7'd5;
        data_in_valid = 1'b1; data_in = 12'h0AB;
        repeat (5) @(negedge clock);
        check("stall_address_ready", 32'(address_in_ready), 0);
        check("stall_data_ready", 32'(data_in_ready), 0);
        address_in_valid = 1'b0;
        data_in_valid = 1'b0;

        // release bank0; third vector's first write one cycle after FILL re-entry
        bank_release = 2'b01;
        track_first = 1'b1;
        @(negedge clock);
        rel_cyc = cyc;
        bank_release = 2'b00;
        mdl_bv[0] = 1'b0;
        vec_addr = '{7'd1, 7'd0};
        vec_data = '{12'h0F1, 12'h000};
        drive_vector(0, 0, 2'b00);
        wait_drain();
        check("refill_first_write_latency", first_we_cyc - rel_cyc, 2);
        check("refill_bank_valid", 32'(bank_valid), 2'b11);
        rel(2'b11);

        // collision: release bank0 in the COMMIT cycle that fills bank0
        random_vector();
        drive_vector(0, 0, 2'b00);
        random_vector();
        drive_vector(0, 0, 2'b01);
        wait_drain();
        check("collision_bank_valid", 32'(bank_valid), 2'b11);
        rel(2'b11);

        // randomized traffic with random backpressure and releases
        for (int v = 0; v < 30; v++) begin
            if ($urandom_range(3) == 0) rel(~mdl_bv);
            if (mdl_bv[mdl_bank]) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                rel(mdl_bank ? 2'b10 : 2'b01);
            end
            random_vector();
            drive_vector(($urandom_range(4) == 0) ? 3 : 0, 30, 2'b00);
        end
        wait_drain();
        check("random_bank_valid", 32'(bank_valid), 32'(mdl_bv));
        check("main_overflow_clear", 32'(overflow), 0);

        // overflow on a 4-entry bank: 6 words then terminator
        check("small_overflow_initial", 32'(s_overflow), 0);
        foreach (sw[i]) sw[i] = WW'($urandom_range(1, 4094));
        di = 0; b = 0;
        while ((di < 7 || s_addr_wr_count == 0) && b < 100) begin
            @(negedge clock);
            b++;
            s_address_in_valid = (s_addr_wr_count == 0) && !s_done_seen;
            s_address_in = '0;
            s_data_in_valid = (di < 7);
            s_data_in = (di < 6) ? sw[di] : '0;
            if (s_data_in_valid && s_data_in_ready) di++;
        end
        @(negedge clock);
        s_address_in_valid = 1'b0;
        s_data_in_valid = 1'b0;
        b = 0;
        while (!s_done_seen && b < 50) begin @(negedge clock); b++; end
        #1;
        check("small_done_seen", 32'(s_done_seen), 1);
        for (int i = 0; i < 3; i++) check("small_kept_word", 32'(s_mem[i]), 32'(sw[i]));
        check("small_terminator_last_index", 32'(s_mem[3]), 0);
        check("small_data_write_count", s_data_wr_count, 4);
        check("small_addr_write", 32'({s_addr_wr_count[3:0], s_last_addr_wdata}), 32'({4'd1, 7'd0}));
        check("small_overflow", 32'(s_overflow), 1);
        check("small_data_len", 32'(s_vector_data_len), 4);
        check("small_addr_len", 32'(s_vector_addr_len), 1);
        check("small_bank", 32'({s_vector_bank, s_bank_valid}), 32'({1'b0, 2'b01}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
